// File: rtl/memory_channel_initiator_if.sv
// rtl/memory_channel_initiator_if.sv - CPU load/store port and memory controller channel signals
// The master modport is the initiator's view; slave is the CPU/controller side.
interface memory_channel_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_write_value;
    logic        rsp_valid;
    logic        rsp_error;
    logic [31:0] rsp_read_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [31:0] mem_req_address;
    logic [31:0] mem_req_write_data;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic        mem_rsp_error;
    logic [31:0] mem_rsp_read_data;

    modport master (
        input  req_valid, req_write, req_funct3, req_address, req_write_value,
        output req_ready, rsp_valid, rsp_error, rsp_read_data,
        output mem_req_valid, mem_req_write, mem_req_address, mem_req_write_data,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_error, mem_rsp_read_data,
        output mem_rsp_ready
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_address, req_write_value,
        input  req_ready, rsp_valid, rsp_error, rsp_read_data,
        input  mem_req_valid, mem_req_write, mem_req_address, mem_req_write_data,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_error, mem_rsp_read_data,
        input  mem_rsp_ready
    );
endinterface

// File: rtl/memory_channel_initiator.sv
// rtl/memory_channel_initiator.sv - RISC-V load/store to word-aligned memory channel initiator
// Optional feature macro MEM_INITIATOR_RMW_STORE_EN: SB/SH via read-modify-write (else rejected).
module memory_channel_initiator #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clock,
    input  logic                              clear_n,
    memory_channel_initiator_if.master        bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_ISSUE,
        S_READ_WAIT,
        S_WRITE_ISSUE,
        S_WRITE_WAIT,
        S_RESPOND
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  timer_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
`ifdef MEM_INITIATOR_RMW_STORE_EN
    logic        write_q;
    logic [31:0] value_q;
`endif

    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_error_q;
    logic [31:0] rsp_read_data_q;
    logic        mem_req_valid_q;
    logic        mem_req_write_q;
    logic [29:0] mem_word_q;
    logic [31:0] mem_req_write_data_q;
    logic        mem_rsp_ready_q;

    logic        decode_err_d;
    logic        timeout_d;
    logic [4:0]  shamt_d;
    logic [31:0] lane_word_d;
    logic [31:0] load_data_d;

    always_comb begin
        decode_err_d = 1'b0;
        if (bus.req_write) begin
`ifdef MEM_INITIATOR_RMW_STORE_EN
            decode_err_d = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
`else
            decode_err_d = (bus.req_funct3 != 3'b010);
`endif
        end else begin
            decode_err_d = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        if (bus.req_funct3[1:0] == 2'b01 && bus.req_address[0]) begin
            decode_err_d = 1'b1;
        end
        if (bus.req_funct3[1:0] == 2'b10 && bus.req_address[1:0] != 2'b00) begin
            decode_err_d = 1'b1;
        end
    end

    assign timeout_d   = (timer_q == TIMEOUT_LAST);
    assign shamt_d     = {lane_q, 3'b000};
    assign lane_word_d = bus.mem_rsp_read_data >> shamt_d;

    always_comb begin
        case (funct3_q)
            3'b000:  load_data_d = {{24{lane_word_d[7]}}, lane_word_d[7:0]};
            3'b001:  load_data_d = {{16{lane_word_d[15]}}, lane_word_d[15:0]};
            3'b100:  load_data_d = {24'h0, lane_word_d[7:0]};
            3'b101:  load_data_d = {16'h0, lane_word_d[15:0]};
            default: load_data_d = bus.mem_rsp_read_data;
        endcase
    end

`ifdef MEM_INITIATOR_RMW_STORE_EN
    logic [31:0] lane_mask_d;
    logic [31:0] store_word_d;

    // funct3[0] distinguishes SH from SB; the other bytes of the read word are preserved.
    assign lane_mask_d  = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt_d;
    assign store_word_d = (bus.mem_rsp_read_data & ~lane_mask_d) | ((value_q << shamt_d) & lane_mask_d);
`endif

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q              <= S_IDLE;
            timer_q              <= '0;
            funct3_q             <= '0;
            lane_q               <= '0;
`ifdef MEM_INITIATOR_RMW_STORE_EN
            write_q              <= 1'b0;
            value_q              <= '0;
`endif
            req_ready_q          <= 1'b1;
            rsp_valid_q          <= 1'b0;
            rsp_error_q          <= 1'b0;
            rsp_read_data_q      <= '0;
            mem_req_valid_q      <= 1'b0;
            mem_req_write_q      <= 1'b0;
            mem_word_q           <= '0;
            mem_req_write_data_q <= '0;
            mem_rsp_ready_q      <= 1'b0;
        end else begin
            rsp_valid_q     <= 1'b0;
            rsp_error_q     <= 1'b0;
            rsp_read_data_q <= '0;
            timer_q         <= timer_q + 8'd1;
            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (bus.req_valid) begin
                        funct3_q    <= bus.req_funct3;
                        lane_q      <= bus.req_address[1:0];
`ifdef MEM_INITIATOR_RMW_STORE_EN
                        write_q     <= bus.req_write;
                        value_q     <= bus.req_write_value;
`endif
                        req_ready_q <= 1'b0;
                        if (decode_err_d) begin
                            state_q     <= S_RESPOND;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                        end else if (bus.req_write && bus.req_funct3 == 3'b010) begin
                            state_q              <= S_WRITE_ISSUE;
                            mem_req_valid_q      <= 1'b1;
                            mem_req_write_q      <= 1'b1;
                            mem_word_q           <= bus.req_address[31:2];
                            mem_req_write_data_q <= bus.req_write_value;
                        end else begin
                            // Loads and the read half of a sub-word store.
                            state_q              <= S_READ_ISSUE;
                            mem_req_valid_q      <= 1'b1;
                            mem_req_write_q      <= 1'b0;
                            mem_word_q           <= bus.req_address[31:2];
                            mem_req_write_data_q <= '0;
                        end
                    end
                end
                S_READ_ISSUE, S_WRITE_ISSUE: begin
                    if (bus.mem_req_ready) begin
                        state_q         <= (state_q == S_READ_ISSUE) ? S_READ_WAIT : S_WRITE_WAIT;
                        timer_q         <= '0;
                        mem_req_valid_q <= 1'b0;
                        mem_rsp_ready_q <= 1'b1;
                    end else if (timeout_d) begin
                        state_q         <= S_RESPOND;
                        mem_req_valid_q <= 1'b0;
                        rsp_valid_q     <= 1'b1;
                        rsp_error_q     <= 1'b1;
                    end
                end
                S_READ_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        mem_rsp_ready_q <= 1'b0;
                        timer_q         <= '0;
                        if (bus.mem_rsp_error) begin
                            state_q     <= S_RESPOND;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
`ifdef MEM_INITIATOR_RMW_STORE_EN
                        end else if (write_q) begin
                            state_q              <= S_WRITE_ISSUE;
                            mem_req_valid_q      <= 1'b1;
                            mem_req_write_q      <= 1'b1;
                            mem_req_write_data_q <= store_word_d;
`endif
                        end else begin
                            state_q         <= S_RESPOND;
                            rsp_valid_q     <= 1'b1;
                            rsp_read_data_q <= load_data_d;
                        end
                    end else if (timeout_d) begin
                        state_q         <= S_RESPOND;
                        mem_rsp_ready_q <= 1'b0;
                        rsp_valid_q     <= 1'b1;
                        rsp_error_q     <= 1'b1;
                    end
                end
                S_WRITE_WAIT: begin
                    if (bus.mem_rsp_valid || timeout_d) begin
                        state_q         <= S_RESPOND;
                        mem_rsp_ready_q <= 1'b0;
                        rsp_valid_q     <= 1'b1;
                        rsp_error_q     <= bus.mem_rsp_valid ? bus.mem_rsp_error : 1'b1;
                    end
                end
                S_RESPOND: begin
                    state_q              <= S_IDLE;
                    req_ready_q          <= 1'b1;
                    mem_req_write_q      <= 1'b0;
                    mem_word_q           <= '0;
                    mem_req_write_data_q <= '0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready          = req_ready_q;
    assign bus.rsp_valid          = rsp_valid_q;
    assign bus.rsp_error          = rsp_error_q;
    assign bus.rsp_read_data      = rsp_read_data_q;
    assign bus.mem_req_valid      = mem_req_valid_q;
    assign bus.mem_req_write      = mem_req_write_q;
    assign bus.mem_req_address    = {mem_word_q, 2'b00};
    assign bus.mem_req_write_data = mem_req_write_data_q;
    assign bus.mem_rsp_ready      = mem_rsp_ready_q;
endmodule

// File: tb/tb_memory_channel_initiator.sv
// tb/tb_memory_channel_initiator.sv - self-checking bench for memory_channel_initiator
// Memory controller model of 4 KiB (errors above 0x1000) plus a reference load/store model.
module tb_memory_channel_initiator;
    logic clock = 1'b0;
    logic clear_n;
    always #5 clock = ~clock;

    memory_channel_initiator_if bus_if ();
    memory_channel_initiator dut (.clock(clock), .clear_n(clear_n), .bus(bus_if));

`ifdef MEM_INITIATOR_RMW_STORE_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif

    typedef struct {
        bit        err;
        bit [31:0] data;
        int        lat;
        int        rd;
        int        wr;
        bit [31:0] word_addr;
        bit        chk_mem;
        int        mem_idx;
        bit [31:0] mem_val;
    } exp_t;

    exp_t      exp_q[$];
    exp_t      cmp_e;
    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;
    int        acc_cnt = 0;
    int        rsp_cnt = 0;
    int        acc_cyc = 0;
    int        rd_base = 0;
    int        wr_base = 0;
    int        rd_total = 0;
    int        wr_total = 0;
    int        stall_until = 0;
    int        rsp_delay = 0;
    bit        mon_en = 1'b0;
    bit        ready_chk_en = 1'b0;
    bit        last_err;
    bit [31:0] last_data;
    bit [31:0] last_rd_addr;
    bit [31:0] ref_mem [1024];
    bit [31:0] mem [1024];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Memory controller: single outstanding request, response rsp_delay+1 cycles after handshake.
    initial begin : responder
        int        pend;
        bit        p_err;
        bit [31:0] p_data;
        pend = 0;
        p_err = 1'b0;
        p_data = '0;
        mem[4] = 32'h8081_8283;
        mem[8] = 32'h1122_3344;
        bus_if.mem_req_ready     = 1'b1;
        bus_if.mem_rsp_valid     = 1'b0;
        bus_if.mem_rsp_error     = 1'b0;
        bus_if.mem_rsp_read_data = '0;
        forever begin
            @(negedge clock);
            bus_if.mem_rsp_valid     = 1'b0;
            bus_if.mem_rsp_error     = 1'b0;
            bus_if.mem_rsp_read_data = '0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus_if.mem_rsp_valid     = 1'b1;
                    bus_if.mem_rsp_error     = p_err;
                    bus_if.mem_rsp_read_data = p_data;
                end
            end
            bus_if.mem_req_ready = (cyc >= stall_until);
            if (bus_if.mem_req_valid && bus_if.mem_req_ready) begin
                p_err  = (bus_if.mem_req_address >= 32'h1000);
                p_data = '0;
                if (bus_if.mem_req_write) begin
                    wr_total++;
                    if (!p_err) mem[bus_if.mem_req_address[11:2]] = bus_if.mem_req_write_data;
                end else begin
                    rd_total++;
                    last_rd_addr = bus_if.mem_req_address;
                    if (!p_err) p_data = mem[bus_if.mem_req_address[11:2]];
                end
                pend = 1 + rsp_delay;
            end
        end
    end

    always @(negedge clock) begin
        if (mon_en) begin
            if (ready_chk_en) chk("req_ready", 32'(bus_if.req_ready), 32'(acc_cnt == rsp_cnt));
            if (bus_if.mem_req_valid) chk("mem_req_address_align", 32'(bus_if.mem_req_address[1:0]), 32'd0);
            if (bus_if.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    fail_bound("unexpected_rsp_valid");
                end else begin
                    cmp_e = exp_q.pop_front();
                    chk("rsp_error", 32'(bus_if.rsp_error), 32'(cmp_e.err));
                    chk("rsp_read_data", bus_if.rsp_read_data, cmp_e.data);
                    chk("latency", 32'(cyc - acc_cyc + 1), 32'(cmp_e.lat));
                    chk("mem_reads", 32'(rd_total - rd_base), 32'(cmp_e.rd));
                    chk("mem_writes", 32'(wr_total - wr_base), 32'(cmp_e.wr));
                    if (cmp_e.rd > 0) chk("mem_read_address", last_rd_addr, cmp_e.word_addr);
                    if (cmp_e.chk_mem) chk("memory_word", mem[cmp_e.mem_idx], cmp_e.mem_val);
                    rsp_cnt++;
                end
                last_err  = bus_if.rsp_error;
                last_data = bus_if.rsp_read_data;
            end
        end
    end

    // Reference behaviour computed from the load/store rules directly.
    task automatic model(input bit w, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] v,
                         input int stall, output exp_t e);
        int        lane;
        int        idx;
        int        size;
        bit        legal;
        bit        rmw;
        bit [31:0] word;
        bit [31:0] shifted;
        bit [31:0] b;
        bit [31:0] h;
        e = '{default: 0};
        lane = int'(a % 4);
        idx = int'((a / 4) % 1024);
        e.word_addr = a - 32'(lane);
        if (w) legal = (f3 == 3'd2) || (RMW_EN && (f3 == 3'd0 || f3 == 3'd1));
        else   legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size = 1 << f3[1:0];
        if (!legal || (a % size) != 0) begin
            e.err = 1'b1;
            e.lat = 1;
            return;
        end
        if (stall >= 255) begin
            e.err = 1'b1;
            e.lat = 256;
            return;
        end
        rmw = w && (f3 != 3'd2);
        e.lat = (rmw ? 5 : 3) + stall;
        if (a >= 32'h1000) begin
            e.err = 1'b1;
            e.lat = 3 + stall;
            e.wr = (w && !rmw) ? 1 : 0;
            e.rd = (w && !rmw) ? 0 : 1;
            return;
        end
        e.rd = (!w || rmw) ? 1 : 0;
        e.wr = w ? 1 : 0;
        word = ref_mem[idx];
        shifted = word >> (8 * lane);
        b = shifted % 256;
        h = shifted % 65536;
        if (!w) begin
            case (f3)
                3'd0:    e.data = (b < 128) ? b : b + 32'hFFFF_FF00;
                3'd1:    e.data = (h < 32768) ? h : h + 32'hFFFF_0000;
                3'd4:    e.data = b;
                3'd5:    e.data = h;
                default: e.data = word;
            endcase
        end else begin
            if (f3 == 3'd2) word = v;
            else if (f3 == 3'd0) word = word - (b << (8 * lane)) + ((v % 256) << (8 * lane));
            else word = word - (h << (8 * lane)) + ((v % 65536) << (8 * lane));
            ref_mem[idx] = word;
            e.chk_mem = 1'b1;
            e.mem_idx = idx;
            e.mem_val = word;
        end
    endtask

    task automatic send(input bit w, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] v,
                        input int stall, input bit track);
        int n;
        n = 0;
        @(negedge clock);
        while (!bus_if.req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!bus_if.req_ready) fail_bound("req_ready_wait");
        bus_if.req_valid       = 1'b1;
        bus_if.req_write       = w;
        bus_if.req_funct3      = f3;
        bus_if.req_address     = a;
        bus_if.req_write_value = v;
        @(posedge clock);
        #1;
        bus_if.req_valid       = 1'b0;
        bus_if.req_write       = 1'b0;
        bus_if.req_funct3      = '0;
        bus_if.req_address     = '0;
        bus_if.req_write_value = '0;
        acc_cyc     = cyc;
        rd_base     = rd_total;
        wr_base     = wr_total;
        stall_until = cyc + stall;
        if (track) acc_cnt++;
    endtask

    task automatic req(input bit w, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] v, input int stall);
        exp_t e;
        int   n;
        model(w, f3, a, v, stall, e);
        exp_q.push_back(e);
        send(w, f3, a, v, stall, 1'b1);
        n = 0;
        while (rsp_cnt != acc_cnt && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (rsp_cnt != acc_cnt) fail_bound("response_wait");
    endtask

    task automatic lit(input string name, input bit err, input bit [31:0] data);
        chk({name, "_error"}, 32'(last_err), 32'(err));
        chk({name, "_data"}, last_data, data);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(bus_if.req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'd0);
        chk({tag, "_rsp_error"}, 32'(bus_if.rsp_error), 32'd0);
        chk({tag, "_rsp_read_data"}, bus_if.rsp_read_data, 32'd0);
        chk({tag, "_mem_req_valid"}, 32'(bus_if.mem_req_valid), 32'd0);
        chk({tag, "_mem_req_write"}, 32'(bus_if.mem_req_write), 32'd0);
        chk({tag, "_mem_req_address"}, bus_if.mem_req_address, 32'd0);
        chk({tag, "_mem_req_write_data"}, bus_if.mem_req_write_data, 32'd0);
        chk({tag, "_mem_rsp_ready"}, 32'(bus_if.mem_rsp_ready), 32'd0);
    endtask

    initial begin
        int snap;
        clear_n                = 1'b0;
        bus_if.req_valid       = 1'b0;
        bus_if.req_write       = 1'b0;
        bus_if.req_funct3      = '0;
        bus_if.req_address     = '0;
        bus_if.req_write_value = '0;
        ref_mem[4] = 32'h8081_8283;
        ref_mem[8] = 32'h1122_3344;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset("init");
        clear_n      = 1'b1;
        mon_en       = 1'b1;
        ready_chk_en = 1'b1;

        req(1'b0, 3'd0, 32'h11, 0, 0); lit("lb_11", 1'b0, 32'hFFFF_FF82);
        req(1'b0, 3'd4, 32'h13, 0, 0); lit("lbu_13", 1'b0, 32'h0000_0080);
        req(1'b0, 3'd1, 32'h12, 0, 0); lit("lh_12", 1'b0, 32'hFFFF_8081);
        req(1'b0, 3'd2, 32'h10, 0, 0); lit("lw_10", 1'b0, 32'h8081_8283);
        req(1'b0, 3'd5, 32'h10, 0, 0); lit("lhu_10", 1'b0, 32'h0000_8283);
        req(1'b0, 3'd0, 32'h10, 0, 0); lit("lb_10", 1'b0, 32'hFFFF_FF83);

        req(1'b1, 3'd0, 32'h12, 32'h0000_00AB, 0); lit("sb_12", !RMW_EN, 32'h0);
        req(1'b0, 3'd2, 32'h10, 0, 0);
        lit("lw_after_sb", 1'b0, RMW_EN ? 32'h80AB_8283 : 32'h8081_8283);
        req(1'b1, 3'd1, 32'h22, 32'hFFFF_5566, 0);
        req(1'b0, 3'd2, 32'h20, 0, 0);
        lit("lw_after_sh", 1'b0, RMW_EN ? 32'h5566_3344 : 32'h1122_3344);
        req(1'b1, 3'd2, 32'h24, 32'hDEAD_BEEF, 0);
        req(1'b0, 3'd2, 32'h24, 0, 0); lit("lw_after_sw", 1'b0, 32'hDEAD_BEEF);

        req(1'b0, 3'd2, 32'h02, 0, 0); lit("lw_misaligned", 1'b1, 32'h0);
        req(1'b0, 3'd1, 32'h11, 0, 0); lit("lh_misaligned", 1'b1, 32'h0);
        req(1'b0, 3'd3, 32'h10, 0, 0);
        req(1'b1, 3'd4, 32'h10, 32'h1, 0);
        req(1'b1, 3'd1, 32'h13, 32'h1, 0);
        req(1'b0, 3'd2, 32'h2000, 0, 0); lit("lw_out_of_range", 1'b1, 32'h0);
        req(1'b1, 3'd2, 32'h2000, 32'h1234_5678, 0);
        req(1'b1, 3'd0, 32'h2001, 32'h0000_0055, 0);
        req(1'b0, 3'd5, 32'h12, 0, 7);
        lit("lhu_stalled", 1'b0, RMW_EN ? 32'h0000_80AB : 32'h0000_8081);

        req(1'b0, 3'd2, 32'h10, 0, 300); lit("timeout", 1'b1, 32'h0);
        snap = rd_total;
        repeat (60) @(negedge clock);
        chk("no_issue_after_timeout", 32'(rd_total), 32'(snap));

        ready_chk_en = 1'b0;
        rsp_delay    = 4;
        send(1'b0, 3'd2, 32'h10, 0, 0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        chk("mem_rsp_ready_in_wait", 32'(bus_if.mem_rsp_ready), 32'd1);
        clear_n = 1'b0;
        @(negedge clock);
        check_reset("mid_op");
        clear_n = 1'b1;
        repeat (12) @(negedge clock);
        chk("idle_after_ignored_rsp", 32'(bus_if.req_ready), 32'd1);
        rsp_delay    = 0;
        ready_chk_en = 1'b1;
        req(1'b0, 3'd2, 32'h24, 0, 0); lit("lw_after_reset", 1'b0, 32'hDEAD_BEEF);

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/memory_channel_initiator.md
# memory_channel_initiator

Load/store initiator that drives one channel of the shared memory controller. It converts CPU load/store requests (RISC-V byte/halfword/word, signed/unsigned) into word-aligned controller transactions, returning sign- or zero-extended load data. Sub-word stores are done by read-modify-write, and the block detects misalignment and timeouts. It sits between the execute stage and one `ch_to_controller` / `controller_to_ch` channel pair.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles spent waiting for either a `mem_req_ready` or a `mem_rsp_valid` before the operation is aborted with an error; 8-bit counter.
- `clock` in 1: sole clock, rising edge.
- `clear_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: CPU request present.
- `req_ready` out 1: block accepts a request; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- `req_address` in 32: byte address.
- `req_write_value` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse; no back-pressure.
- `rsp_error` out 1: qualified by `rsp_valid`.
- `rsp_read_data` out 32: extended load data, 0 for stores and errors.
- `mem_req_valid` out 1; `mem_req_ready` in 1; `mem_req_write` out 1; `mem_req_address` out 32, always `[1:0]`=00; `mem_req_write_data` out 32.
- `mem_rsp_valid` in 1; `mem_rsp_ready` out 1; `mem_rsp_error` in 1; `mem_rsp_read_data` in 32.

## Operation
- States: IDLE, READ_ISSUE, READ_WAIT, WRITE_ISSUE, WRITE_WAIT, RESPOND.
- IDLE: `req_ready`=1. On `req_valid`, latch the request, then decode:
  - An illegal `funct3`, or misalignment (H with `addr[0]`=1, W with `addr[1:0]`≠0), goes to RESPOND with error set. No memory request is issued.
  - LW/LB/LH/LBU/LHU goes to READ_ISSUE.
  - SW goes to WRITE_ISSUE with `write_data` = value.
  - SB/SH go to READ_ISSUE for the RMW read.
- READ_ISSUE / WRITE_ISSUE:
  - `mem_req_valid`=1, with `mem_req_address` = `{addr[31:2],2'b00}` and write/data held stable until `mem_req_ready`.
  - On the handshake, move to the matching _WAIT state.
- READ_WAIT / WRITE_WAIT:
  - `mem_rsp_ready`=1; the state completes on `mem_rsp_valid`.
  - `mem_rsp_error`=1 goes to RESPOND with error set. An RMW read error skips the write.
  - Load: lane = `addr[1:0]`. Select the byte/half at bit offset 8·lane, sign-extend (LB/LH) or zero-extend (LBU/LHU), register it, and go to RESPOND.
  - RMW read: merge the new byte/half into the read word at lane offset, keeping the other bytes, then go to WRITE_ISSUE.
  - Write completion goes to RESPOND.
- RESPOND: `rsp_valid`=1 for exactly one cycle, then IDLE.
- Timeout:
  - The counter resets on every state entry and counts in the ISSUE/WAIT states.
  - Reaching `TIMEOUT_CYCLES` goes to RESPOND with error set.
  - A response arriving later is ignored: `mem_rsp_valid` is don't-care outside the WAIT states.
- `mem_rsp_ready` is 0 outside the WAIT states.

## Timing
- Reset (`clear_n`=0 at an edge):
  - State goes to IDLE.
  - Outputs: `req_ready`=1; `rsp_valid`, `rsp_error`, `rsp_read_data`, all `mem_req_*` and `mem_rsp_ready` = 0.
  - Reset mid-operation abandons the operation. A write already handshaked completes in memory; no CPU response is produced.
- Request accepted at edge 0 goes to READ_ISSUE in cycle 1.
  - With the controller granting immediately, the handshake is in cycle 1 and the response in cycle 2.
  - `rsp_valid` follows in cycle 3: minimum load/SW latency is 3 cycles accept-to-`rsp_valid`.
- Minimum sub-word store latency is 5 cycles.
- Error decoded in IDLE gives `rsp_valid` in cycle 1.
- `mem_req_ready` may be low for many cycles, as with the round-robin grant. The request is held unchanged; there is no combinational path from `mem_req_ready` to `mem_req_valid`.
- `req_ready` drops the cycle after acceptance and returns the cycle after RESPOND. Back-to-back requests are therefore spaced by at least one IDLE cycle.

## Configuration
- `MEM_INITIATOR_RMW_STORE_EN`:
  - Defined: SB/SH use read-modify-write as above.
  - Undefined: SB/SH go straight to RESPOND with `rsp_error`=1 and no memory traffic. READ-then-WRITE sequencing logic is omitted; loads and SW are unchanged.

## Test plan
- Word 0x10 = 0x80818283, LB @0x11 -> `rsp_read_data`=0xFFFFFF82, error 0, exactly one read request at address 0x10.
- LBU @0x13 -> 0x00000080; LH @0x12 -> 0xFFFF8081; LW @0x10 -> 0x80818283.
- SB @0x12 value 0x000000AB on word 0x80818283 -> one read then one write, memory = 0x80AB8283, `rsp_error`=0. Without the macro: `rsp_error`=1 and memory unchanged.
- LW @0x02 and LH @0x11 -> `rsp_valid` one cycle after acceptance, `rsp_error`=1, `mem_req_valid` never asserted.
- LW @0x2000 (out of controller range) -> controller error -> `rsp_error`=1, `rsp_read_data`=0.
- Hold `mem_req_ready`=0 for 300 cycles -> error after 255 cycles. Separately, drop `clear_n` in READ_WAIT -> IDLE next cycle, all outputs at reset values, and the later `mem_rsp_valid` is ignored.
